// File: rtl/typedefs_pkg.sv
// Shared constants for data_memory: MMIO register offsets, store-mask encodings
// and the misaligned-store rule used by the store path.
package typedefs_pkg;

  typedef enum logic [3:0] {
    MASK_BYTE = 4'b0001,
    MASK_HALF = 4'b0011,
    MASK_WORD = 4'b1111
  } store_mask_e;

  typedef enum logic [3:0] {
    OFS_CYC_LO  = 4'h0,
    OFS_CYC_HI  = 4'h4,
    OFS_SCRATCH = 4'h8,
    OFS_STATUS  = 4'hC
  } mmio_ofs_e;

  // A store is legal only if it uses a known mask and its lanes stay inside one word.
  function automatic logic store_misaligned(input logic [3:0] mask, input logic [1:0] ofs);
    case (mask)
      MASK_BYTE: return 1'b0;
      MASK_HALF: return ofs == 2'd3;
      MASK_WORD: return ofs != 2'd0;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Word-wide RAM built from four byte lanes: one write enable per lane,
// asynchronous read of the addressed word. Contents are not reset.
module byte_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    lane_we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (lane_we[gi]) mem_q[addr] <= wdata[8*gi +: 8];
    end

    assign rdata[8*gi +: 8] = mem_q[addr];
  end

endmodule

// File: rtl/data_memory.sv
// Core data memory: byte-lane RAM with zero-latency loads, sticky misaligned-store flag,
// and an optional MMIO register window enabled by defining DATA_MEMORY_MMIO_EN.
module data_memory
  import typedefs_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_wr_mask,
  output logic [31:0] dmem_rdata,
  output logic        err_misaligned
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [1:0]  byte_ofs;
  logic        in_window;
  logic        ram_hit;
  logic        misaligned;
  logic        store_ok;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] word_rd;
  logic        err_q;
  logic        err_d;

  assign byte_ofs   = dmem_addr[1:0];
  assign in_window  = dmem_addr[31:4] == MMIO_BASE[31:4];
  // The register window is carved out of RAM if a configuration ever overlaps them.
  assign ram_hit    = ({1'b0, dmem_addr} < RAM_BYTES) && !in_window;
  assign misaligned = dmem_wen && store_misaligned(dmem_wr_mask, byte_ofs);
  assign store_ok   = dmem_wen && !misaligned && rst_n;
  assign lane_we    = dmem_wr_mask << byte_ofs;
  assign lane_wdata = dmem_wdata << {byte_ofs, 3'b000};
  assign ram_we     = (store_ok && ram_hit) ? lane_we : 4'b0000;

  byte_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_byte_ram (
    .clk     (clk),
    .addr    (dmem_addr[AW+1:2]),
    .lane_we (ram_we),
    .wdata   (lane_wdata),
    .rdata   (ram_rdata)
  );

`ifdef DATA_MEMORY_MMIO_EN
  mmio_ofs_e   reg_ofs;
  logic        mmio_we;
  logic        status_clr;
  logic [63:0] cycle_q;
  logic [31:0] scratch_q;
  logic [31:0] scratch_d;

  assign reg_ofs    = mmio_ofs_e'({dmem_addr[3:2], 2'b00});
  assign mmio_we    = store_ok && in_window;
  assign status_clr = mmio_we && (reg_ofs == OFS_STATUS) && lane_we[0] && lane_wdata[0];

  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (mmio_we && (reg_ofs == OFS_SCRATCH) && lane_we[i])
        scratch_d[8*i +: 8] = lane_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      scratch_q <= '0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      scratch_q <= scratch_d;
    end
  end

  // A new fault wins over a simultaneous clear so it is never lost.
  always_comb begin
    err_d = err_q;
    if (status_clr) err_d = 1'b0;
    if (misaligned) err_d = 1'b1;
  end

  always_comb begin
    word_rd = '0;
    if (ram_hit) begin
      word_rd = ram_rdata;
    end else if (in_window) begin
      case (reg_ofs)
        OFS_CYC_LO:  word_rd = cycle_q[31:0];
        OFS_CYC_HI:  word_rd = cycle_q[63:32];
        OFS_SCRATCH: word_rd = scratch_q;
        OFS_STATUS:  word_rd = {31'd0, err_q};
        default:     word_rd = '0;
      endcase
    end
  end
`else
  always_comb begin
    err_d = err_q | misaligned;
  end

  always_comb begin
    word_rd = '0;
    if (ram_hit) word_rd = ram_rdata;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign dmem_rdata     = word_rd >> {byte_ofs, 3'b000};
  assign err_misaligned = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against a byte-addressed reference model;
// MMIO register checks are compiled in when DATA_MEMORY_MMIO_EN is defined.
module tb_data_memory;

  localparam int          DEPTH = 64;
  localparam int          BYTES = DEPTH * 4;
  localparam logic [31:0] MMIO  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_wen = 1'b0;
  logic [3:0]  dmem_wr_mask = '0;
  logic [31:0] dmem_rdata;
  logic        err_misaligned;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [BYTES];
  logic       err_m = 1'b0;

  always #5 clk = ~clk;

  data_memory #(
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (MMIO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wen       (dmem_wen),
    .dmem_wr_mask   (dmem_wr_mask),
    .dmem_rdata     (dmem_rdata),
    .err_misaligned (err_misaligned)
  );

  // ---------------- reference model ----------------
  function automatic int mask_size(logic [3:0] mask);
    case (mask)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_misaligned(logic [3:0] mask, logic [31:0] addr);
    int sz;
    sz = mask_size(mask);
    if (sz == 0) return 1'b1;
    return (int'(addr[1:0]) + sz) > 4;
  endfunction

  task automatic model_store(logic [31:0] addr, logic [31:0] data, logic [3:0] mask, logic wen);
    if (!wen) return;
    if (model_misaligned(mask, addr)) begin
      err_m = 1'b1;
      return;
    end
    if (addr < BYTES) begin
      for (int i = 0; i < mask_size(mask); i++) mem_m[int'(addr) + i] = data[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(logic [31:0] addr);
    logic [31:0] r;
    r = '0;
    if (addr < BYTES) begin
      for (int i = 0; i < 4; i++)
        if (int'(addr[1:0]) + i < 4) r[8*i +: 8] = mem_m[int'(addr) + i];
    end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_store(logic [31:0] addr, logic [31:0] data, logic [3:0] mask, logic wen);
    @(negedge clk);
    dmem_addr    = addr;
    dmem_wdata   = data;
    dmem_wr_mask = mask;
    dmem_wen     = wen;
    @(posedge clk);
    model_store(addr, data, mask, wen);
    #1;
    dmem_wen = 1'b0;
    $display("store addr=%08h data=%08h mask=%04b wen=%0b", addr, data, mask, wen);
  endtask

  task automatic check_read(string name, logic [31:0] addr, logic [31:0] exp);
    @(negedge clk);
    dmem_addr = addr;
    dmem_wen  = 1'b0;
    #1;
    checks++;
    if (dmem_rdata !== exp) begin
      errors++;
      $display("FAIL %s addr=%08h got=%08h expected=%08h", name, addr, dmem_rdata, exp);
    end
  endtask

  task automatic check_err(string name);
    checks++;
    if (err_misaligned !== err_m) begin
      errors++;
      $display("FAIL %s err_misaligned got=%0b expected=%0b", name, err_misaligned, err_m);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    err_m = 1'b0;
    #2;
    check_err("reset_clears_err");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_err("reset_state_err");
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < DEPTH; w++) do_store(32'(w * 4), $urandom, 4'hF, 1'b1);
    check_err("after_init_err");
    check_read("init_word0", 32'h0, model_read(32'h0));
    check_read("init_last", 32'(BYTES - 4), model_read(32'(BYTES - 4)));
  endtask

  task automatic test_directed();
    do_store(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    check_read("sw_read", 32'h10, 32'hDEAD_BEEF);
    check_read("sw_read_ofs2", 32'h12, 32'h0000_DEAD);
    do_store(32'h13, 32'h0000_00AA, 4'b0001, 1'b1);
    check_read("sb_read", 32'h10, 32'hAAAD_BEEF);
    check_err("sb_no_err");
    do_store(32'h13, 32'h0000_1234, 4'b0011, 1'b1);
    check_read("sh_mis_ram_unchanged", 32'h10, 32'hAAAD_BEEF);
    check_err("sh_mis_err_set");
    do_store(32'h11, 32'h0000_5678, 4'b0011, 1'b1);
    check_read("sh_ofs1_ok", 32'h10, 32'hAA56_78EF);
    check_err("err_sticky");
    do_store(32'h14, 32'h1111_1111, 4'b0101, 1'b1);
    check_read("bad_mask_suppressed", 32'h14, model_read(32'h14));
    do_store(32'h18, 32'h2222_2222, 4'b1111, 1'b0);
    check_read("wen0_no_write", 32'h18, model_read(32'h18));
  endtask

  task automatic test_unmapped();
    logic [31:0] snap [DEPTH];
    for (int w = 0; w < DEPTH; w++) snap[w] = model_read(32'(w * 4));
    check_read("oob_read", 32'(BYTES), 32'h0);
    do_store(32'(BYTES), 32'hCAFE_F00D, 4'hF, 1'b1);
    do_store(32'(BYTES + 4), 32'h0000_0077, 4'h1, 1'b1);
    check_read("oob_read_after_write", 32'(BYTES), 32'h0);
    for (int w = 0; w < DEPTH; w++) check_read("oob_ram_unchanged", 32'(w * 4), snap[w]);
`ifndef DATA_MEMORY_MMIO_EN
    do_store(MMIO + 32'h8, 32'h1234_5678, 4'hF, 1'b1);
    check_read("window_unmapped_scratch", MMIO + 32'h8, 32'h0);
    check_read("window_unmapped_cyc", MMIO, 32'h0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    for (int n = 0; n < 8; n++) begin
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      d = $urandom;
      @(negedge clk);
      dmem_addr = a; dmem_wdata = d; dmem_wr_mask = 4'hF; dmem_wen = 1'b1;
      #1;
      checks++;
      if (dmem_rdata !== model_read(a)) begin
        errors++;
        $display("FAIL rdw_old_data addr=%08h got=%08h expected=%08h", a, dmem_rdata, model_read(a));
      end
      @(posedge clk);
      model_store(a, d, 4'hF, 1'b1);
      $display("store addr=%08h data=%08h mask=1111 wen=1 (back-to-back)", a, d);
      #1;
      checks++;
      if (dmem_rdata !== d) begin
        errors++;
        $display("FAIL rdw_next_cycle addr=%08h got=%08h expected=%08h", a, dmem_rdata, d);
      end
    end
    @(negedge clk);
    dmem_wen = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] ra;
    logic [3:0]  m;
    for (int n = 0; n < 300; n++) begin
      if (n % 60 == 59) pulse_reset();
      if ($urandom_range(0, 99) < 85) a = 32'($urandom_range(0, BYTES - 1));
      else                            a = 32'(BYTES + $urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       m = 4'b0001;
        1:       m = 4'b0011;
        2:       m = 4'b1111;
        default: m = 4'($urandom);
      endcase
      do_store(a, $urandom, m, $urandom_range(0, 7) != 0);
      check_err("rand_err");
      ra = ($urandom_range(0, 9) == 0) ? 32'(BYTES + $urandom_range(0, 63))
                                       : 32'($urandom_range(0, BYTES - 1));
      check_read("rand_read", ra, model_read(ra));
    end
  endtask

  task automatic test_reset_mid_store();
    do_store(32'h21, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check_err("pre_reset_err_set");
    @(negedge clk);
    dmem_addr = 32'h20; dmem_wdata = 32'h5A5A_5A5A; dmem_wr_mask = 4'hF; dmem_wen = 1'b1;
    #2;
    rst_n = 1'b0;
    err_m = 1'b0;
    #1;
    check_err("async_reset_err");
    @(negedge clk);
    dmem_wen = 1'b0;
    rst_n = 1'b1;
    check_read("reset_store_ignored", 32'h20, model_read(32'h20));
    check_err("post_reset_err");
  endtask

`ifdef DATA_MEMORY_MMIO_EN
  task automatic test_mmio();
    @(negedge clk);
    rst_n = 1'b0;
    err_m = 1'b0;
    dmem_addr = MMIO;
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mmio_cyc_in_reset got=%08h expected=00000000", dmem_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dmem_rdata !== 32'd10) begin
      errors++;
      $display("FAIL mmio_cyc_lo_10 got=%08h expected=0000000a", dmem_rdata);
    end
    dmem_addr = MMIO + 32'h4;
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mmio_cyc_hi_0 got=%08h expected=00000000", dmem_rdata);
    end
    @(negedge clk);
    force dut.cycle_q = '1;
    dmem_addr = MMIO;
    #1;
    checks++;
    if (dmem_rdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mmio_forced_lo got=%08h expected=ffffffff", dmem_rdata);
    end
    release dut.cycle_q;
    @(posedge clk);
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mmio_wrap_lo got=%08h expected=00000000", dmem_rdata);
    end
    dmem_addr = MMIO + 32'h4;
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mmio_wrap_hi got=%08h expected=00000000", dmem_rdata);
    end
    do_store(MMIO + 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check_read("mmio_hi_ro", MMIO + 32'h4, 32'h0);
    do_store(MMIO + 32'h8, 32'h1122_3344, 4'hF, 1'b1);
    check_read("scratch_word", MMIO + 32'h8, 32'h1122_3344);
    do_store(MMIO + 32'h9, 32'h0000_00AB, 4'h1, 1'b1);
    check_read("scratch_byte", MMIO + 32'h8, 32'h1122_AB44);
    do_store(MMIO + 32'hA, 32'h0000_5566, 4'h3, 1'b1);
    check_read("scratch_half", MMIO + 32'h8, 32'h5566_AB44);
    check_read("scratch_ofs2", MMIO + 32'hA, 32'h0000_5566);
    do_store(32'h3, 32'h0, 4'h3, 1'b1);
    check_err("status_set");
    check_read("status_read_1", MMIO + 32'hC, 32'h1);
    do_store(MMIO + 32'hC, 32'h0000_0000, 4'hF, 1'b1);
    check_err("status_w0_keeps");
    do_store(MMIO + 32'hC, 32'h0000_0001, 4'h1, 1'b1);
    err_m = 1'b0;
    check_err("status_w1c");
    check_read("status_read_0", MMIO + 32'hC, 32'h0);
    @(negedge clk);
    dmem_addr = MMIO + 32'h8; dmem_wdata = 32'hFFFF_FFFF; dmem_wr_mask = 4'hF; dmem_wen = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL scratch_async_reset got=%08h expected=00000000", dmem_rdata);
    end
    @(negedge clk);
    dmem_wen = 1'b0;
    rst_n = 1'b1;
    check_read("scratch_reset_store_ignored", MMIO + 32'h8, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_reset_mid_store();
`ifdef DATA_MEMORY_MMIO_EN
    test_mmio();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000, base byte address of the memory-mapped register window.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dmem_addr  input  32  byte address from core.
REQ-006 SHALL have port dmem_wdata  input  32  store data, right-aligned (byte/half in low bits).
REQ-007 SHALL have port dmem_wen  input  1  store request for the current cycle.
REQ-008 SHALL have port dmem_wr_mask  input  4  unshifted lane mask: 0001 byte, 0011 half, 1111 word.
REQ-009 SHALL have port dmem_rdata  output  32  load data, combinational.
REQ-010 SHALL have port err_misaligned  output  1  sticky misaligned-store flag.

Function
REQ-011 SHALL decode RAM hit as dmem_addr < DEPTH_WORDS*4; word index = dmem_addr[log2(DEPTH_WORDS)+1:2].
REQ-012 SHALL drive dmem_rdata combinationally (zero latency) = addressed aligned word shifted right by 8*dmem_addr[1:0], zero-filled.
REQ-013 SHALL shift dmem_wr_mask and dmem_wdata left by dmem_addr[1:0] lanes and write enabled byte lanes on the rising edge when dmem_wen=1.
REQ-014 SHALL treat a store as misaligned when half mask at addr[1:0]=3, or word mask at addr[1:0]!=0, or mask not in {0001,0011,1111}.
REQ-015 SHALL suppress misaligned stores entirely (no lane written) and set err_misaligned on that edge.
REQ-016 SHALL return 0 on reads and ignore writes for addresses hitting neither RAM nor an implemented register.
REQ-017 SHALL, with dmem_wen=0, leave all storage unchanged regardless of dmem_wr_mask.
REQ-018 SHALL make a store visible to reads from the following cycle (read-during-write returns old data).

Reset
REQ-019 SHALL asynchronously clear err_misaligned and all MMIO registers while rst_n=0; RAM contents are not reset.
REQ-020 SHALL ignore dmem_wen while rst_n=0; release is synchronous to clk edges for state updates.

Configuration
REQ-021 SHALL, when DATA_MEMORY_MMIO_EN is defined, implement word registers at MMIO_BASE offsets: 0x0 cycle count low (RO), 0x4 cycle count high (RO), 0x8 scratch (RW, byte-masked), 0xC status (bit0 = err_misaligned, write-1-to-clear).
REQ-022 SHALL, with DATA_MEMORY_MMIO_EN, increment a 64-bit cycle counter every clk edge out of reset, wrapping from all-ones to 0; writes to 0x0/0x4 ignored.
REQ-023 SHALL, with DATA_MEMORY_MMIO_EN, give set priority over W1C when a misaligned store and a status clear coincide (impossible in one store, but defined for future ports).
REQ-024 SHALL, without DATA_MEMORY_MMIO_EN, treat the MMIO window as unmapped (REQ-016); err_misaligned clears only by reset.

Structure
REQ-025 SHALL place MMIO offset constants and the store-mask encodings in typedefs_pkg.
REQ-026 SHALL implement byte-lane RAM as sub-module byte_ram (parameterised depth, per-lane write enable, async read).

Verification
REQ-027 SHALL cover: sw 32'hDEAD_BEEF @0x10, mask 1111 -> next-cycle read @0x10 = DEAD_BEEF, @0x12 = 0000_DEAD.
REQ-028 SHALL cover: sb 32'h0000_00AA @0x13 over DEAD_BEEF -> read @0x10 = AAAD_BEEF; err_misaligned stays 0.
REQ-029 SHALL cover: sh 32'h1234 @0x13 -> RAM unchanged, err_misaligned=1 next cycle, remains 1 until reset (or W1C to 0xC with MMIO).
REQ-030 SHALL cover: read @DEPTH_WORDS*4 -> 0; write there -> no RAM word changes.
REQ-031 SHALL cover (MMIO): 10 cycles after reset release, read MMIO_BASE+0x0 = 10, +0x4 = 0; force counter 0xFFFF_FFFF_FFFF_FFFF -> next cycle both words 0.
REQ-032 SHALL cover: assert rst_n=0 mid-store with dmem_wen=1 -> no write, err and MMIO registers 0 immediately.
